cs_resolve_pipe: RTL

CS_RESOLVE_PIPE -- requirements
Module: cs_resolve_pipe

---
 rtl/cs_resolve_pipe.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cs_resolve_pipe.sv
// cs_resolve_pipe: two-stage carry-save to binary resolver with valid/ready flow control.
// Stage 1 adds the low halves of the sum and carry rows and keeps the carry out.
// Stage 2 adds the high halves plus that carry and presents the product.
// The carry out of the top bit is dropped, so product = (sum + carry) mod 2^(2*WIDTH).
// WIDTH must be even and at least 4.
module cs_resolve_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   sum,
    input  logic [2*WIDTH-1:0]   carry,
    input  logic                 tc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_tc,
    output logic [15:0]          op_count
);

    localparam int DW = 2 * WIDTH;

    // Stage 1 state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_lo;
    logic             s1_cout;
    logic [WIDTH-1:0] s1_sum_hi;
    logic [WIDTH-1:0] s1_carry_hi;
    logic             s1_tc;

    // Handshake terms
    logic s2_ready;
    logic in_fire;
    logic s1_move;
    logic out_fire;

    // Combinational adders for each half
    logic [WIDTH:0]   lo_add;
    logic [WIDTH-1:0] hi_add;

    // Stage 2 can take new data when empty or when its current word leaves this cycle.
    // Stage 1 can take new data when empty or when it is moving into stage 2.
    always_comb begin
        s2_ready = !out_valid || out_ready;
        in_ready = !s1_valid || s2_ready;
        in_fire  = in_valid && in_ready;
        s1_move  = s1_valid && s2_ready;
        out_fire = out_valid && out_ready;
    end

    // Low-half add keeps one extra bit for the carry into the high half.
    always_comb begin
        lo_add = {1'b0, sum[WIDTH-1:0]} + {1'b0, carry[WIDTH-1:0]};
    end

    // High-half add wraps at WIDTH bits, discarding the top carry.
    always_comb begin
        hi_add = s1_sum_hi + s1_carry_hi + WIDTH'(s1_cout);
    end

    // Stage 1 occupancy: a load wins over a simultaneous move so new data is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 1 data registers only load on an accepted input; otherwise they hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_lo       <= '0;
            s1_cout     <= 1'b0;
            s1_sum_hi   <= '0;
            s1_carry_hi <= '0;
            s1_tc       <= 1'b0;
        end else if (in_fire) begin
            s1_lo       <= lo_add[WIDTH-1:0];
            s1_cout     <= lo_add[WIDTH];
            s1_sum_hi   <= sum[DW-1:WIDTH];
            s1_carry_hi <= carry[DW-1:WIDTH];
            s1_tc       <= tc;
        end
    end

    // Stage 2 occupancy: refilled from stage 1, emptied by an output transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
        end else if (s1_move) begin
            out_valid <= 1'b1;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Stage 2 data: loads only when stage 1 advances, so a stalled output stays stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            product <= '0;
            out_tc  <= 1'b0;
        end else if (s1_move) begin
            product <= {hi_add, s1_lo};
            out_tc  <= s1_tc;
        end
    end

    // Delivered-product counter, saturating at all ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_count <= 16'd0;
        end else if (out_fire && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule
